// File: rtl/coloring_pkg.sv
// Shared field offsets, header width and FSM states for the frame-buffer colouring stream.
package coloring_pkg;

  localparam int X_LSB        = 0;
  localparam int Y_LSB        = 8;
  localparam int COLOR_LSB    = 16;
  localparam int HDR_CNT_BITS = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    HDR   = 2'd1,
    PIX   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Frame-buffer storage: simple dual-port, byte-enabled write, registered read-first read.
// Latency: read data valid the cycle after re; no back-pressure, no reset on contents.
module fb_ram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // A read and a clearing write to the same word in one cycle return the old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/coloring_fb_stream.sv
// Paints culled pixel batches into an on-chip frame and, every NUM_BATCHES batches, streams the frame out.
// Latency: first frame word 2 cycles after the drain starts, then 1 word/cycle; the frame is cleared as it is read.
// Back-pressure: in_ready low during clear/drain; out_ready low stalls the drain with no loss via a 2-entry skid FIFO.
module coloring_fb_stream
  import coloring_pkg::*;
#(
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int NUM_BATCHES = 3192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int WORDS = IMG_W * IMG_H / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW    = $clog2(NUM_BATCHES + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic [BW-1:0] BATCH_MAX = BW'(NUM_BATCHES);

  state_t state, state_nxt;

  logic [AW-1:0]           addr_cnt;
  logic [HDR_CNT_BITS-1:0] pix_left;
  logic [BW-1:0]           batch_cnt;
  logic                    issued_all;
  logic                    rd_inflight;

  logic [31:0] fifo_q [2];
  logic        fifo_rd_ptr;
  logic        fifo_wr_ptr;
  logic [1:0]  fifo_cnt;

  logic [3:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [7:0]              pix_x, pix_y, pix_color;
  logic [HDR_CNT_BITS-1:0] hdr_cnt;
  logic                    pix_in_range;
  logic [AW-1:0]           pix_addr;
  logic [BW-1:0]           batch_inc;
  logic                    in_xfer, out_xfer;
  logic [2:0]              fifo_occ;
  logic                    rd_issue;
  logic                    drain_done;
  logic                    unused_in_bits;

  assign pix_x     = in_data[X_LSB +: 8];
  assign pix_y     = in_data[Y_LSB +: 8];
  assign pix_color = in_data[COLOR_LSB +: 8];
  assign hdr_cnt   = in_data[HDR_CNT_BITS-1:0];
  assign unused_in_bits = ^in_data[31:24];

  assign pix_in_range = ({1'b0, pix_x} < 9'(IMG_W)) && ({1'b0, pix_y} < 9'(IMG_H));
  assign pix_addr     = AW'(17'(pix_y) * 17'(IMG_W / 4) + 17'(pix_x[7:2]));
  assign batch_inc    = batch_cnt + BW'(1);

  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_q[fifo_rd_ptr];
  assign out_xfer  = out_valid && out_ready;

  // Room check counts the read in flight and credits a word leaving this cycle, so the drain streams back-to-back.
  assign fifo_occ   = 3'(fifo_cnt) + 3'(rd_inflight) - 3'(out_xfer);
  assign rd_issue   = (state == DRAIN) && !issued_all && (fifo_occ < 3'd2);
  assign drain_done = (state == DRAIN) && out_xfer && (fifo_cnt == 2'd1) && !rd_inflight && issued_all;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ram_we    = 4'h0;
    ram_waddr = addr_cnt;
    ram_wdata = 32'h0;
    case (state)
      CLEAR: begin
        ram_we = 4'hF;
        if (addr_cnt == LAST_ADDR) state_nxt = HDR;
      end
      HDR: begin
        in_ready = 1'b1;
        if (in_xfer) begin
          if (hdr_cnt != '0)               state_nxt = PIX;
          else if (batch_inc == BATCH_MAX) state_nxt = DRAIN;
        end
      end
      PIX: begin
        in_ready = 1'b1;
        if (in_xfer) begin
          if (pix_in_range) begin
            ram_we    = lane_mask(pix_x[1:0]);
            ram_waddr = pix_addr;
            ram_wdata = {4{pix_color}};
          end
          if (pix_left == HDR_CNT_BITS'(1))
            state_nxt = (batch_cnt == BATCH_MAX) ? DRAIN : HDR;
        end
      end
      DRAIN: begin
        if (rd_issue)   ram_we = 4'hF;
        if (drain_done) state_nxt = HDR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt    <= '0;
      pix_left    <= '0;
      batch_cnt   <= '0;
      issued_all  <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      case (state)
        CLEAR: addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + AW'(1);
        HDR: begin
          if (in_xfer) begin
            pix_left  <= hdr_cnt;
            batch_cnt <= batch_inc;
          end
        end
        PIX: begin
          if (in_xfer) pix_left <= pix_left - HDR_CNT_BITS'(1);
        end
        DRAIN: begin
          if (rd_issue) begin
            if (addr_cnt == LAST_ADDR) issued_all <= 1'b1;
            else                       addr_cnt   <= addr_cnt + AW'(1);
          end
          if (drain_done) begin
            addr_cnt   <= '0;
            issued_all <= 1'b0;
            batch_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (rd_inflight) begin
        fifo_q[fifo_wr_ptr] <= ram_rdata;
        fifo_wr_ptr         <= ~fifo_wr_ptr;
      end
      if (out_xfer) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_inflight) - 2'(out_xfer);
    end
  end

  fb_ram #(
    .DEPTH (WORDS),
    .AW    (AW)
  ) u_fb_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_issue),
    .raddr (addr_cnt),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_coloring_fb_stream.sv
// Random and directed frames against a pixel-level frame model; 8x4 image, 2 batches per frame.
module tb_coloring_fb_stream;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NW = W * H / 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fb [W*H];
  logic [31:0] got [NW];

  coloring_fb_stream #(.IMG_W(W), .IMG_H(H), .NUM_BATCHES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return {fb[4*i+3], fb[4*i+2], fb[4*i+1], fb[4*i]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < W*H; i++) fb[i] = 8'h00;
  endtask

  task automatic reset_dut();
    int cnt;
    logic ov_seen;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    cnt = 0; ov_seen = 1'b0;
    while (!in_ready && cnt < 50) begin
      if (out_valid) ov_seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", cnt, 8);
    chk("clear_out_valid", ov_seen, 0);
    model_clear();
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    if ($urandom_range(3) == 0) begin
      @(negedge clk);
    end
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_hdr(input int n);
    logic [15:0] junk;
    junk = 16'($urandom);
    send({junk, 16'(n)});
  endtask

  task automatic send_pix(input int x, input int y, input logic [7:0] c);
    send({8'h00, c, 8'(y), 8'(x)});
    if (x < W && y < H) fb[y*W + x] = c;
  endtask

  // Collects `take` drain words; a full frame is compared against the model, which is then cleared.
  task automatic collect(input int pct, input int take);
    int n, cyc, first, last;
    logic stall, rdy_seen;
    logic [31:0] held;
    n = 0; cyc = 0; first = -1; last = -1;
    stall = 1'b0; rdy_seen = 1'b0; held = '0;
    while (n < take && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (in_ready) rdy_seen = 1'b1;
      if (stall) chk("stall_hold", {31'h0, out_valid, out_data}, {31'h0, 1'b1, held});
      if (out_valid && first < 0) first = cyc;
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        got[n] = out_data; n++; last = cyc; stall = 1'b0;
      end else if (out_valid) begin
        stall = 1'b1; held = out_data;
      end
    end
    chk("drain_words", n, take);
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (take == NW) begin
      chk("first_valid_lat", first, 3);
      chk("in_ready_in_drain", rdy_seen, 0);
      if (pct == 100) chk("burst_len", last - first, NW - 1);
      for (int i = 0; i < NW; i++) chk($sformatf("word%0d", i), got[i], exp_word(i));
      @(negedge clk);
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      model_clear();
    end
  endtask

  task automatic rand_batches();
    for (int b = 0; b < 2; b++) begin
      int n;
      n = $urandom_range(0, 5);
      send_hdr(n);
      for (int k = 0; k < n; k++)
        send_pix($urandom_range(0, 9), $urandom_range(0, 5), 8'($urandom));
    end
  endtask

  initial begin
    model_clear();
    reset_dut();

    // Single pixel, then an empty batch closes the frame.
    send_hdr(1);
    send_pix(5, 1, 8'hAA);
    send_hdr(0);
    collect(100, NW);
    chk("aa_word3", got[3], 32'h0000AA00);
    chk("aa_word0", got[0], 32'h0);

    // Overwrite of the same pixel plus an out-of-range pixel.
    send_hdr(3);
    send_pix(2, 2, 8'h11);
    send_pix(2, 2, 8'h22);
    send_pix(9, 0, 8'h55);
    send_hdr(0);
    collect(50, NW);
    chk("dup_word4", got[4], 32'h00220000);

    // Second frame must see the previous contents cleared.
    send_hdr(1);
    send_pix(0, 0, 8'h33);
    send_hdr(0);
    collect(100, NW);
    chk("c33_word0", got[0], 32'h00000033);
    chk("c33_word4", got[4], 32'h0);

    for (int f = 0; f < 4; f++) begin
      rand_batches();
      collect(50, NW);
    end

    // Reset in the middle of a pixel batch discards the partial frame.
    send_hdr(3);
    send_pix(1, 1, 8'h77);
    reset_dut();
    rand_batches();
    collect(50, NW);

    // Reset in the middle of a drain.
    send_hdr(2);
    send_pix(4, 0, 8'h5A);
    send_pix(7, 3, 8'hC3);
    send_hdr(0);
    collect(50, 3);
    reset_dut();
    rand_batches();
    collect(100, NW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
